// File: rtl/pkt_buf_ring.sv
// pkt_buf_ring: N-buffer packet memory manager shared by snooper, CPU and forwarder.
// Buffers rotate in strict ring order: fill -> classify -> forward or free.
module pkt_buf_ring #(
    parameter int unsigned N_BUFS     = 3,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          snooper_wr_addr,
    input  logic [DATA_WIDTH-1:0]          snooper_wr_data,
    input  logic                           snooper_wr_en,
    input  logic                           snooper_done,
    output logic                           ready_for_snooper,
    input  logic [ADDR_WIDTH-1:0]          cpu_rd_addr,
    input  logic                           cpu_rd_en,
    output logic [DATA_WIDTH-1:0]          cpu_rd_data,
    output logic [ADDR_WIDTH:0]            cpu_pkt_len,
    input  logic                           cpu_acc,
    input  logic                           cpu_rej,
    output logic                           ready_for_cpu,
    input  logic [ADDR_WIDTH-1:0]          forwarder_rd_addr,
    input  logic                           forwarder_rd_en,
    output logic [DATA_WIDTH-1:0]          forwarder_rd_data,
    output logic [ADDR_WIDTH:0]            fwd_pkt_len,
    input  logic                           forwarder_done,
    output logic                           ready_for_forwarder,
    output logic [$clog2(N_BUFS+1)-1:0]    bufs_free
);

    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W  = (N_BUFS > 1) ? $clog2(N_BUFS) : 1;
    localparam int unsigned LEN_W  = ADDR_WIDTH + 1;
    localparam int unsigned FREE_W = $clog2(N_BUFS + 1);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        CPU_PEND = 2'd1,
        FWD_PEND = 2'd2,
        REJ_PEND = 2'd3
    } buf_state_t;

    buf_state_t             state_q [N_BUFS];
    buf_state_t             state_d [N_BUFS];
    logic [LEN_W-1:0]       len_q   [N_BUFS];
    logic [LEN_W-1:0]       len_d   [N_BUFS];
    logic [PTR_W-1:0]       fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0]       cpu_ptr_q,  cpu_ptr_d;
    logic [PTR_W-1:0]       fwd_ptr_q,  fwd_ptr_d;
    logic [FREE_W-1:0]      bufs_free_d;
    logic [LEN_W-1:0]       wr_len;
    logic [DATA_WIDTH-1:0]  mem [N_BUFS][DEPTH];

    // Ring advance with wrap at N_BUFS-1 (N_BUFS need not be a power of 2).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_BUFS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Port readiness decoded from the registered state of each pointer's buffer.
    assign ready_for_snooper   = (state_q[fill_ptr_q] == EMPTY);
    assign ready_for_cpu       = (state_q[cpu_ptr_q]  == CPU_PEND);
    assign ready_for_forwarder = (state_q[fwd_ptr_q]  == FWD_PEND);
    assign cpu_pkt_len         = len_q[cpu_ptr_q];
    assign fwd_pkt_len         = len_q[fwd_ptr_q];

    // Next-state: each pointer targets a buffer in a distinct state, so all events apply together.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        fill_ptr_d  = fill_ptr_q;
        cpu_ptr_d   = cpu_ptr_q;
        fwd_ptr_d   = fwd_ptr_q;
        bufs_free_d = '0;
        wr_len      = LEN_W'(snooper_wr_addr) + LEN_W'(1);

        if (snooper_wr_en && ready_for_snooper && (wr_len > len_q[fill_ptr_q])) begin
            len_d[fill_ptr_q] = wr_len;
        end
        if (snooper_done && ready_for_snooper) begin
            state_d[fill_ptr_q] = CPU_PEND;
            fill_ptr_d          = next_ptr(fill_ptr_q);
        end

        if (ready_for_cpu && (cpu_acc || cpu_rej)) begin
            state_d[cpu_ptr_q] = cpu_acc ? FWD_PEND : REJ_PEND;
            cpu_ptr_d          = next_ptr(cpu_ptr_q);
        end

        if ((state_q[fwd_ptr_q] == REJ_PEND) || (forwarder_done && ready_for_forwarder)) begin
            state_d[fwd_ptr_q] = EMPTY;
            len_d[fwd_ptr_q]   = '0;
            fwd_ptr_d          = next_ptr(fwd_ptr_q);
        end

        for (int i = 0; i < int'(N_BUFS); i++) begin
            if (state_d[i] == EMPTY) begin
                bufs_free_d = bufs_free_d + FREE_W'(1);
            end
        end
    end

    // Buffer state, lengths, ring pointers and free count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_BUFS); i++) begin
                state_q[i] <= EMPTY;
                len_q[i]   <= '0;
            end
            fill_ptr_q <= '0;
            cpu_ptr_q  <= '0;
            fwd_ptr_q  <= '0;
            bufs_free  <= FREE_W'(N_BUFS);
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            fill_ptr_q <= fill_ptr_d;
            cpu_ptr_q  <= cpu_ptr_d;
            fwd_ptr_q  <= fwd_ptr_d;
            bufs_free  <= bufs_free_d;
        end
    end

    // Snooper write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (snooper_wr_en && ready_for_snooper) begin
            mem[fill_ptr_q][snooper_wr_addr] <= snooper_wr_data;
        end
    end

    // Registered CPU and forwarder read ports; hold value when not strobed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rd_data       <= '0;
            forwarder_rd_data <= '0;
        end else begin
            if (cpu_rd_en) begin
                cpu_rd_data <= mem[cpu_ptr_q][cpu_rd_addr];
            end
            if (forwarder_rd_en) begin
                forwarder_rd_data <= mem[fwd_ptr_q][forwarder_rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_pkt_buf_ring.sv
// Directed bench for pkt_buf_ring with 3 buffers of 1024 x 32-bit words.
module tb_pkt_buf_ring;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  snooper_wr_addr = '0;
    logic [31:0] snooper_wr_data = '0;
    logic        snooper_wr_en = 1'b0;
    logic        snooper_done = 1'b0;
    logic        ready_for_snooper;
    logic [9:0]  cpu_rd_addr = '0;
    logic        cpu_rd_en = 1'b0;
    logic [31:0] cpu_rd_data;
    logic [10:0] cpu_pkt_len;
    logic        cpu_acc = 1'b0;
    logic        cpu_rej = 1'b0;
    logic        ready_for_cpu;
    logic [9:0]  forwarder_rd_addr = '0;
    logic        forwarder_rd_en = 1'b0;
    logic [31:0] forwarder_rd_data;
    logic [10:0] fwd_pkt_len;
    logic        forwarder_done = 1'b0;
    logic        ready_for_forwarder;
    logic [1:0]  bufs_free;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] pkt_b [14] = '{
        32'h70b31760, 32'h0a1b2c3d, 32'h4e5f6071, 32'h08004500,
        32'h003c1c46, 32'h40004006, 32'hb1e6ac10, 32'h0a63ac10,
        32'h0a0c0050, 32'h1f90a6b2, 32'h00000000, 32'h50027d78,
        32'h12340000, 32'h0000FFFF
    };

    pkt_buf_ring #(.N_BUFS(3), .ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .snooper_wr_addr     (snooper_wr_addr),
        .snooper_wr_data     (snooper_wr_data),
        .snooper_wr_en       (snooper_wr_en),
        .snooper_done        (snooper_done),
        .ready_for_snooper   (ready_for_snooper),
        .cpu_rd_addr         (cpu_rd_addr),
        .cpu_rd_en           (cpu_rd_en),
        .cpu_rd_data         (cpu_rd_data),
        .cpu_pkt_len         (cpu_pkt_len),
        .cpu_acc             (cpu_acc),
        .cpu_rej             (cpu_rej),
        .ready_for_cpu       (ready_for_cpu),
        .forwarder_rd_addr   (forwarder_rd_addr),
        .forwarder_rd_en     (forwarder_rd_en),
        .forwarder_rd_data   (forwarder_rd_data),
        .fwd_pkt_len         (fwd_pkt_len),
        .forwarder_done      (forwarder_done),
        .ready_for_forwarder (ready_for_forwarder),
        .bufs_free           (bufs_free)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        snooper_wr_addr = 10'(a);
        snooper_wr_data = d;
        snooper_wr_en   = 1'b1;
        step();
        snooper_wr_en   = 1'b0;
    endtask

    task automatic done_pulse();
        snooper_done = 1'b1;
        step();
        snooper_done = 1'b0;
    endtask

    task automatic fill_b();
        for (int i = 0; i < 14; i++) wr(i, pkt_b[i]);
        done_pulse();
    endtask

    task automatic fill_pat(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) wr(i, base + 32'(i));
        done_pulse();
    endtask

    task automatic classify(input logic a, input logic r);
        cpu_acc = a;
        cpu_rej = r;
        step();
        cpu_acc = 1'b0;
        cpu_rej = 1'b0;
    endtask

    task automatic fwd_done();
        forwarder_done = 1'b1;
        step();
        forwarder_done = 1'b0;
    endtask

    task automatic cpu_read(input int a);
        cpu_rd_addr = 10'(a);
        cpu_rd_en   = 1'b1;
        step();
        cpu_rd_en   = 1'b0;
    endtask

    task automatic fwd_read(input int a);
        forwarder_rd_addr = 10'(a);
        forwarder_rd_en   = 1'b1;
        step();
        forwarder_rd_en   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1;
        do_reset();
        check("rst_rdy_snoop", 32'(ready_for_snooper), 32'd1);
        check("rst_rdy_cpu",   32'(ready_for_cpu), 32'd0);
        check("rst_rdy_fwd",   32'(ready_for_forwarder), 32'd0);
        check("rst_free",      32'(bufs_free), 32'd3);
        check("rst_cpu_data",  cpu_rd_data, 32'd0);
        check("rst_fwd_data",  forwarder_rd_data, 32'd0);

        // Single 14-word packet handed to the CPU
        fill_b();
        check("t2_rdy_cpu",  32'(ready_for_cpu), 32'd1);
        check("t2_cpu_len",  32'(cpu_pkt_len), 32'd14);
        check("t2_free",     32'(bufs_free), 32'd2);
        cpu_read(3);
        check("t2_cpu_rd3",  cpu_rd_data, 32'h08004500);

        // All buffers full, ignored write, then drain and wrap
        do_reset();
        fill_pat(32'h1000, 4);
        fill_pat(32'h2000, 6);
        fill_pat(32'h3000, 2);
        check("t3_rdy_snoop_full", 32'(ready_for_snooper), 32'd0);
        check("t3_free_full",      32'(bufs_free), 32'd0);
        wr(0, 32'hDEADBEEF);
        cpu_read(0);
        check("t3_ignored_wr",     cpu_rd_data, 32'h1000);
        check("t3_cpu_len",        32'(cpu_pkt_len), 32'd4);
        classify(1'b1, 1'b0);
        check("t3_rdy_fwd",        32'(ready_for_forwarder), 32'd1);
        check("t3_fwd_len",        32'(fwd_pkt_len), 32'd4);
        classify(1'b0, 1'b1);
        classify(1'b0, 1'b1);
        check("t3_rdy_cpu_drained", 32'(ready_for_cpu), 32'd0);
        repeat (50) step();
        check("t3_rdy_fwd_held",   32'(ready_for_forwarder), 32'd1);
        fwd_done();
        check("t3_rdy_snoop_wrap", 32'(ready_for_snooper), 32'd1);
        check("t3_free_1",         32'(bufs_free), 32'd1);
        step();
        step();
        check("t3_free_3",         32'(bufs_free), 32'd3);
        check("t3_rdy_fwd_idle",   32'(ready_for_forwarder), 32'd0);
        fill_pat(32'h4000, 3);
        check("t3_wrap_rdy_cpu",   32'(ready_for_cpu), 32'd1);
        check("t3_wrap_cpu_len",   32'(cpu_pkt_len), 32'd3);

        // Rejected packet freed without forwarder action
        do_reset();
        fill_pat(32'hDEADBEEF, 11);
        fill_b();
        check("t4_a_len",      32'(cpu_pkt_len), 32'd11);
        cpu_read(0);
        check("t4_a_word0",    cpu_rd_data, 32'hDEADBEEF);
        classify(1'b0, 1'b1);
        check("t4_rdy_cpu_b",  32'(ready_for_cpu), 32'd1);
        check("t4_b_len",      32'(cpu_pkt_len), 32'd14);
        check("t4_rej_no_fwd", 32'(ready_for_forwarder), 32'd0);
        classify(1'b1, 1'b0);
        check("t4_rdy_fwd",    32'(ready_for_forwarder), 32'd1);
        check("t4_fwd_len",    32'(fwd_pkt_len), 32'd14);
        check("t4_free",       32'(bufs_free), 32'd2);
        fwd_read(0);
        check("t4_fwd_rd0",    forwarder_rd_data, 32'h70b31760);
        fwd_read(13);
        check("t4_fwd_rd13",   forwarder_rd_data, 32'h0000FFFF);

        // Ignored pulses, length max, accept-wins
        do_reset();
        cpu_acc = 1'b1;
        cpu_rej = 1'b1;
        forwarder_done = 1'b1;
        step();
        cpu_acc = 1'b0;
        cpu_rej = 1'b0;
        forwarder_done = 1'b0;
        check("t5_idle_rdy_cpu", 32'(ready_for_cpu), 32'd0);
        check("t5_idle_rdy_fwd", 32'(ready_for_forwarder), 32'd0);
        check("t5_idle_free",    32'(bufs_free), 32'd3);
        for (int i = 0; i < 5; i++) wr(i, 32'h5000 + 32'(i));
        wr(1, 32'h5555);
        done_pulse();
        check("t5_rdy_cpu",      32'(ready_for_cpu), 32'd1);
        check("t5_len_max",      32'(cpu_pkt_len), 32'd5);
        classify(1'b1, 1'b1);
        check("t5_acc_wins",     32'(ready_for_forwarder), 32'd1);
        check("t5_rdy_cpu_done", 32'(ready_for_cpu), 32'd0);
        check("t5_fwd_len",      32'(fwd_pkt_len), 32'd5);
        fwd_read(1);
        check("t5_fwd_rd1",      forwarder_rd_data, 32'h5555);
        fwd_done();
        check("t5_free",         32'(bufs_free), 32'd3);

        // Reset mid-operation
        do_reset();
        fill_b();
        classify(1'b1, 1'b0);
        fill_pat(32'h6000, 7);
        check("t6_pre_rdy_cpu",  32'(ready_for_cpu), 32'd1);
        check("t6_pre_rdy_fwd",  32'(ready_for_forwarder), 32'd1);
        check("t6_pre_free",     32'(bufs_free), 32'd1);
        cpu_read(2);
        check("t6_pre_cpu_rd",   cpu_rd_data, 32'h6002);
        fwd_read(0);
        check("t6_pre_fwd_rd",   forwarder_rd_data, 32'h70b31760);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rdy_snoop",    32'(ready_for_snooper), 32'd1);
        check("t6_rdy_cpu",      32'(ready_for_cpu), 32'd0);
        check("t6_rdy_fwd",      32'(ready_for_forwarder), 32'd0);
        check("t6_free",         32'(bufs_free), 32'd3);
        check("t6_cpu_len",      32'(cpu_pkt_len), 32'd0);
        check("t6_fwd_len",      32'(fwd_pkt_len), 32'd0);
        check("t6_cpu_data",     cpu_rd_data, 32'd0);
        check("t6_fwd_data",     forwarder_rd_data, 32'd0);
        fill_pat(32'h7000, 2);
        check("t6_new_rdy_cpu",  32'(ready_for_cpu), 32'd1);
        check("t6_new_cpu_len",  32'(cpu_pkt_len), 32'd2);
        cpu_read(1);
        check("t6_new_cpu_rd1",  cpu_rd_data, 32'h7001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
